arb_conv_32b_8b: RTL and testbench

ARB_CONV_32B_8B -- requirements
Module: arb_conv_32b_8b

---
 rtl/arb_conv_32b_8b_pkg.sv | 17 +
 rtl/arb_conv_32b_8b_rr_arbiter.sv | 62 ++++++
 rtl/arb_conv_32b_8b.sv | 129 ++++++++++++
 tb/tb_arb_conv_32b_8b.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_conv_32b_8b_pkg.sv
// -----------------------------------------------------------------------------
// arb_conv_32b_8b_pkg
// Shared definitions for the 32-bit-lane to 8-bit serializer and its arbiter:
// engine state encoding, byte/word widths and the lane index width.
// -----------------------------------------------------------------------------
package arb_conv_32b_8b_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int LANE_W = 3;

endpackage

// File: rtl/arb_conv_32b_8b_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational lane selector. Picks the first requesting lane at or after
// ptr (wrapping LANES-1 -> 0). With ARB_FIXED_PRIO_EN defined the lowest-index
// requester wins and ptr is ignored.
//
// Ports:
//   req     in   LANES   request vector (registered full flags)
//   ptr     in   LANE_W  round-robin start position, < LANES
//   gnt     out  LANES   one-hot grant (all zero when no request)
//   gnt_idx out  LANE_W  index of the granted lane
// -----------------------------------------------------------------------------
module rr_arbiter
    import arb_conv_32b_8b_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [LANES-1:0]  req,
    input  logic [LANE_W-1:0] ptr,
    output logic [LANES-1:0]  gnt,
    output logic [LANE_W-1:0] gnt_idx
);

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        logic found;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < LANES; i++) begin
            if (req[i] && !found) begin
                found   = 1'b1;
                gnt_idx = LANE_W'(i);
            end
        end
        gnt = found ? (LANES'(1) << gnt_idx) : '0;
    end
`else
    // Rotating a doubled copy of the request vector puts the lane at ptr in
    // bit 0, so the first set bit is the round-robin winner.
    logic [2*LANES-1:0] req_rot;

    assign req_rot = {req, req} >> ptr;

    always_comb begin
        logic found;
        int   pos;
        found   = 1'b0;
        gnt_idx = '0;
        pos     = 0;
        for (int i = 0; i < LANES; i++) begin
            if (req_rot[i] && !found) begin
                found = 1'b1;
                pos   = int'(ptr) + i;
                if (pos >= LANES) pos = pos - LANES;
                gnt_idx = LANE_W'(pos);
            end
        end
        gnt = found ? (LANES'(1) << gnt_idx) : '0;
    end
`endif

endmodule

// File: rtl/arb_conv_32b_8b.sv
// -----------------------------------------------------------------------------
// arb_conv_32b_8b
// Arbitrating width converter: LANES 32-bit requesters, each with a one-word
// holding register, share one 8-bit output stream. A granted word is sent
// MSB first over four consecutive cycles; back-to-back grants are gapless.
// Optional build macro: ARB_FIXED_PRIO_EN (fixed lowest-index priority
// instead of round-robin).
//
// Ports:
//   clk_4f     in   1         clock, rising edge
//   reset      in   1         synchronous active-high reset
//   valid_in   in   LANES     per-lane word valid
//   data_in    in   32*LANES  lane i word in [32*i+31:32*i]
//   ready_in   out  LANES     per-lane holding register empty
//   data_out   out  8         serialized byte
//   valid_out  out  1         data_out carries a byte
//   lane_out   out  3         lane owning the current byte
//   sof_out    out  1         first byte of a word
//   eof_out    out  1         last byte of a word
// -----------------------------------------------------------------------------
module arb_conv_32b_8b
    import arb_conv_32b_8b_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                clk_4f,
    input  logic                reset,
    input  logic [LANES-1:0]    valid_in,
    input  logic [32*LANES-1:0] data_in,
    output logic [LANES-1:0]    ready_in,
    output logic [7:0]          data_out,
    output logic                valid_out,
    output logic [2:0]          lane_out,
    output logic                sof_out,
    output logic                eof_out
);

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [LANE_W-1:0]   ptr_q, ptr_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [LANES-1:0]    full_q, full_d;
    logic [WORD_W-1:0]   hold_q [LANES];
    logic [WORD_W-1:0]   hold_d [LANES];

    logic [LANES-1:0]    gnt;
    logic [LANE_W-1:0]   gnt_idx;
    logic                grant;

    rr_arbiter #(.LANES(LANES)) u_arb (
        .req     (full_q),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // A new word may start when idle or on the last byte of the current word.
    assign grant = ((state_q == ST_IDLE) || (state_q == ST_SEND && cnt_q == 2'd3))
                   && (|full_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        lane_d  = lane_q;
        shift_d = shift_q;
        full_d  = full_q;
        hold_d  = hold_q;

        // Capture uses the registered flag, so a lane freed by this edge's
        // grant can only be refilled at the following edge.
        for (int i = 0; i < LANES; i++) begin
            if (valid_in[i] && !full_q[i]) begin
                hold_d[i] = data_in[32*i +: 32];
                full_d[i] = 1'b1;
            end
        end

        if (state_q == ST_SEND) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = shift_q << BYTE_W;
            if (cnt_q == 2'd3) state_d = ST_IDLE;
        end

        if (grant) begin
            for (int i = 0; i < LANES; i++) begin
                if (gnt[i]) shift_d = hold_q[i];
            end
            full_d  = full_d & ~gnt;
            lane_d  = gnt_idx;
            state_d = ST_SEND;
            cnt_d   = 2'd0;
            ptr_d   = (int'(gnt_idx) == LANES - 1) ? '0 : gnt_idx + LANE_W'(1);
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            ptr_q   <= '0;
            lane_q  <= '0;
            shift_q <= '0;
            full_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            lane_q  <= lane_d;
            shift_q <= shift_d;
            full_q  <= full_d;
        end
    end

    // Holding data is qualified by full_q, so it needs no reset.
    always_ff @(posedge clk_4f) begin
        hold_q <= hold_d;
    end

    // Outputs decode registered state only.
    assign ready_in  = ~full_q;
    assign valid_out = (state_q == ST_SEND);
    assign data_out  = valid_out ? shift_q[WORD_W-1 -: BYTE_W] : '0;
    assign lane_out  = valid_out ? lane_q : '0;
    assign sof_out   = valid_out && (cnt_q == 2'd0);
    assign eof_out   = valid_out && (cnt_q == 2'd3);

endmodule

// File: tb/tb_arb_conv_32b_8b.sv
// -----------------------------------------------------------------------------
// tb_arb_conv_32b_8b
// Scoreboard bench: stimulus pushes expected bytes into a queue, a monitor
// on the falling edge pops and compares every byte the DUT presents.
// -----------------------------------------------------------------------------
module tb_arb_conv_32b_8b;

    localparam int LANES = 4;

    logic                clk_4f = 1'b0;
    logic                reset  = 1'b1;
    logic [LANES-1:0]    valid_in = '0;
    logic [32*LANES-1:0] data_in  = '0;
    logic [LANES-1:0]    ready_in;
    logic [7:0]          data_out;
    logic                valid_out;
    logic [2:0]          lane_out;
    logic                sof_out;
    logic                eof_out;

    arb_conv_32b_8b #(.LANES(LANES)) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_out  (lane_out),
        .sof_out   (sof_out),
        .eof_out   (eof_out)
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic [7:0] data;
        logic [2:0] lane;
        logic       sof;
        logic       eof;
        logic       contig;   // must directly follow a valid byte
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic [2:0] lane, input logic first_contig);
        exp_t e;
        for (int b = 0; b < 4; b++) begin
            e.data   = w[31-8*b -: 8];
            e.lane   = lane;
            e.sof    = (b == 0);
            e.eof    = (b == 3);
            e.contig = (b != 0) || first_contig;
            q.push_back(e);
        end
    endtask

    // Monitor
    always @(negedge clk_4f) begin
        if (valid_out === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_byte got=%h lane=%0d", data_out, lane_out);
            end else begin
                mon_e = q.pop_front();
                chk("byte_data", {24'h0, data_out}, {24'h0, mon_e.data});
                chk("byte_lane", {29'h0, lane_out}, {29'h0, mon_e.lane});
                chk("byte_sof", {31'h0, sof_out}, {31'h0, mon_e.sof});
                chk("byte_eof", {31'h0, eof_out}, {31'h0, mon_e.eof});
                if (mon_e.contig) chk("byte_gapless", {31'h0, prev_vld}, 32'h1);
            end
        end else if (valid_out === 1'b0) begin
            chk("idle_outputs_zero", {19'h0, data_out, lane_out, sof_out, eof_out}, 32'h0);
        end
        prev_vld <= valid_out;
    end

    task automatic step();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        valid_in = '0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            step();
            k++;
        end
        chk({name, "_drained"}, q.size(), 32'h0);
        repeat (3) step();
    endtask

    // Offer one word on lane 0 and hold it until it has been captured.
    task automatic send_lane0(input logic [31:0] w);
        int k;
        data_in[31:0] = w;
        valid_in[0]   = 1'b1;
        k = 0;
        while (!ready_in[0] && k < 50) begin
            step();
            k++;
        end
        chk("send_lane0_ready", {31'h0, ready_in[0]}, 32'h1);
        step();
    endtask

    initial begin
        // Reset held 3 cycles
        do_reset(3);
        chk("rst_valid_out", {31'h0, valid_out}, 32'h0);
        chk("rst_data_out", {24'h0, data_out}, 32'h0);
        chk("rst_ready_in", {28'h0, ready_in}, 32'hF);
        chk("rst_lane_sof_eof", {27'h0, lane_out, sof_out, eof_out}, 32'h0);

        // Single word on lane 2
        push_word(32'hA1B2C3D4, 3'd2, 1'b0);
        data_in[95:64] = 32'hA1B2C3D4;
        valid_in       = 4'b0100;
        step();
        chk("t2_ready_captured", {28'h0, ready_in}, 32'hB);
        valid_in = '0;
        step();
        chk("t2_ready_freed", {28'h0, ready_in}, 32'hF);
        drain("t2");

        // All four lanes at once, round-robin from lane 0
        do_reset(1);
        push_word(32'h00010203, 3'd0, 1'b0);
        push_word(32'h10111213, 3'd1, 1'b1);
        push_word(32'h20212223, 3'd2, 1'b1);
        push_word(32'h30313233, 3'd3, 1'b1);
        data_in  = {32'h30313233, 32'h20212223, 32'h10111213, 32'h00010203};
        valid_in = 4'b1111;
        step();
        valid_in = '0;
        drain("t3");

        // Lanes 1 and 3 continuously valid for four words
        do_reset(1);
`ifdef ARB_FIXED_PRIO_EN
        push_word(32'h11AA11AA, 3'd1, 1'b0);
        push_word(32'h11AA11AA, 3'd1, 1'b1);
        push_word(32'h11AA11AA, 3'd1, 1'b1);
        push_word(32'h33BB33BB, 3'd3, 1'b1);
`else
        push_word(32'h11AA11AA, 3'd1, 1'b0);
        push_word(32'h33BB33BB, 3'd3, 1'b1);
        push_word(32'h11AA11AA, 3'd1, 1'b1);
        push_word(32'h33BB33BB, 3'd3, 1'b1);
`endif
        data_in  = {32'h33BB33BB, 32'h0, 32'h11AA11AA, 32'h0};
        valid_in = 4'b1010;
        repeat (10) step();
        valid_in = '0;
        drain("t4");

        // Lane 0 streams three words gaplessly
        do_reset(1);
        push_word(32'h11111111, 3'd0, 1'b0);
        push_word(32'h22222222, 3'd0, 1'b1);
        push_word(32'h33333333, 3'd0, 1'b1);
        send_lane0(32'h11111111);
        send_lane0(32'h22222222);
        send_lane0(32'h33333333);
        valid_in = '0;
        drain("t5");

        // Reset during byte index 2; lane 1 word pending is discarded
        do_reset(1);
        push_word(32'hDEADBEEF, 3'd0, 1'b0);
        q.delete(q.size() - 1);
        data_in  = {32'h0, 32'h0, 32'h55667788, 32'hDEADBEEF};
        valid_in = 4'b0011;
        step();
        valid_in = '0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        chk("t6_valid_after_reset", {31'h0, valid_out}, 32'h0);
        chk("t6_ready_after_reset", {28'h0, ready_in}, 32'hF);
        reset = 1'b0;
        repeat (12) step();
        chk("t6_no_residual", q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
